// File: rtl/aes_pkg.sv
// Shared widths, round count and sequencer state encoding
// for the iterative AES-128 datapath controller.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTES     = 16;
    localparam int AES128_ROUNDS = 10;

    typedef enum logic [1:0] {
        LOAD,
        ROUND,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit register that shifts left one byte at a time
// or takes a full-width parallel load (load wins).
module aes_byte_shifter
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift_en,
    input  logic [7:0]             shift_byte,
    input  logic                   load_en,
    input  logic [AES_BLOCK_W-1:0] load_val,
    output logic [AES_BLOCK_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[AES_BLOCK_W-9:0], shift_byte};
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: byte-serial load, shared
// round/key units for rounds 1..NUM_ROUNDS, byte-serial drain.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int ROUND_LAT  = 1,
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [7:0]             key_byte,
    input  logic [7:0]             state_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             state_out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] rnd_state_o,
    output logic [AES_BLOCK_W-1:0] rnd_key_o,
    output logic [3:0]             rnd_num_o,
    output logic                   rnd_final_o,
    input  logic [AES_BLOCK_W-1:0] rnd_state_i,
    input  logic [AES_BLOCK_W-1:0] rnd_key_i,
    output logic                   busy,
    output logic                   load,
    output logic                   ready
);

    localparam logic [3:0] LAT_LAST  = 4'(ROUND_LAT - 1);
    localparam logic [3:0] RND_LAST  = 4'(NUM_ROUNDS);
    localparam logic [3:0] BYTE_LAST = 4'(AES_BYTES - 1);

    seq_state_e             st;
    logic [3:0]             byte_cnt;
    logic [3:0]             rnd;
    logic [3:0]             lat_cnt;
    logic [AES_BLOCK_W-1:0] key_reg;
    logic [AES_BLOCK_W-1:0] state_reg;

    logic                   in_fire;
    logic                   out_fire;
    logic                   last_byte;
    logic                   round_done;
    logic                   sh_load;
    logic                   sh_shift;
    logic [7:0]             sh_byte;
    logic [AES_BLOCK_W-1:0] sh_val;

    // Handshakes are gated by rst so nothing is accepted in the reset cycle.
    assign in_ready   = rst && enable && (st == LOAD);
    assign out_valid  = rst && enable && (st == DRAIN);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign last_byte  = (byte_cnt == BYTE_LAST);
    assign round_done = rst && enable && (st == ROUND)
                        && (lat_cnt == LAT_LAST);

    assign load  = in_fire && last_byte;
    assign ready = round_done && (rnd == RND_LAST);
    assign busy  = (st != LOAD);

    assign rnd_state_o    = state_reg;
    assign rnd_key_o      = key_reg;
    assign rnd_num_o      = (st == ROUND) ? rnd : 4'd0;
    assign rnd_final_o    = (st == ROUND) && (rnd == RND_LAST);
    assign state_out_byte = state_reg[AES_BLOCK_W-1 -: 8];

    // The 16th beat folds in the initial AddRoundKey on the way in.
    assign sh_load  = load || round_done;
    assign sh_shift = in_fire || out_fire;
    assign sh_byte  = (st == LOAD) ? state_byte : 8'h00;
    assign sh_val   = round_done ? rnd_state_i
                    : ({state_reg[AES_BLOCK_W-9:0], state_byte}
                       ^ {key_reg[AES_BLOCK_W-9:0], key_byte});

    aes_byte_shifter u_state (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (sh_shift),
        .shift_byte (sh_byte),
        .load_en    (sh_load),
        .load_val   (sh_val),
        .q          (state_reg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            st       <= LOAD;
            byte_cnt <= '0;
            rnd      <= '0;
            lat_cnt  <= '0;
            key_reg  <= '0;
        end else if (enable) begin
            unique case (st)
                LOAD: begin
                    if (in_fire) begin
                        key_reg <= {key_reg[AES_BLOCK_W-9:0], key_byte};
                        if (last_byte) begin
                            rnd     <= 4'd1;
                            lat_cnt <= '0;
                            st      <= ROUND;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end
                ROUND: begin
                    if (lat_cnt == LAT_LAST) begin
                        key_reg <= rnd_key_i;
                        lat_cnt <= '0;
                        if (rnd == RND_LAST) begin
                            byte_cnt <= '0;
                            st       <= DRAIN;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                            rnd      <= '0;
                            st       <= LOAD;
                        end else begin
                            byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                end
                default: st <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench: two sequencers (ROUND_LAT 1 and 3) driven by
// behavioural AES round/key-step models; ciphertext checked via queue.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         enable;
    logic [7:0]   key_byte[2];
    logic [7:0]   state_byte[2];
    logic         in_valid[2];
    logic         in_ready[2];
    logic [7:0]   state_out_byte[2];
    logic         out_valid[2];
    logic         out_ready[2];
    logic [127:0] rnd_state_o[2];
    logic [127:0] rnd_key_o[2];
    logic [3:0]   rnd_num_o[2];
    logic         rnd_final_o[2];
    logic [127:0] rnd_state_i[2];
    logic [127:0] rnd_key_i[2];
    logic         busy[2];
    logic         load[2];
    logic         ready[2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ormode[2];

    logic [7:0] sbox_t[256];

    typedef struct {
        int         d;
        logic [7:0] b;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sb_calc(input int x);
        logic [7:0] b;
        b = '0;
        for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                t[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i] ^ k[127-8*i -: 8];
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k,
                                              input logic [3:0] n);
        logic [31:0] w[4];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        tmp = {w[3][23:0], w[3][31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]],
               sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        rc = 8'h01;
        for (int j = 1; j < int'(n); j++) rc = xt(rc);
        tmp = tmp ^ {rc, 24'h0};
        w[0] = w[0] ^ tmp;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key,
                                             input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] k;
        s = pt ^ key;
        k = key;
        for (int n = 1; n <= 10; n++) begin
            k = key_step(k, 4'(n));
            s = aes_round(s, k, n == 10);
        end
        return s;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) sbox_t[x] = sb_calc(x);
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes_round_sequencer #(
            .ROUND_LAT ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .enable         (enable),
            .key_byte       (key_byte[g]),
            .state_byte     (state_byte[g]),
            .in_valid       (in_valid[g]),
            .in_ready       (in_ready[g]),
            .state_out_byte (state_out_byte[g]),
            .out_valid      (out_valid[g]),
            .out_ready      (out_ready[g]),
            .rnd_state_o    (rnd_state_o[g]),
            .rnd_key_o      (rnd_key_o[g]),
            .rnd_num_o      (rnd_num_o[g]),
            .rnd_final_o    (rnd_final_o[g]),
            .rnd_state_i    (rnd_state_i[g]),
            .rnd_key_i      (rnd_key_i[g]),
            .busy           (busy[g]),
            .load           (load[g]),
            .ready          (ready[g])
        );
        assign rnd_key_i[g]   = key_step(rnd_key_o[g], rnd_num_o[g]);
        assign rnd_state_i[g] = aes_round(rnd_state_o[g], rnd_key_i[g],
                                          rnd_final_o[g]);
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ct(input int d, input logic [127:0] ct);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.d = d;
            e.b = ct[127-8*i -: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_block(input int d, input logic [127:0] k,
                              input logic [127:0] p, input bit gaps,
                              output int t);
        int n;
        bit ok;
        t = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid[d] = 1'b0;
                @(posedge clk); #1;
            end
            key_byte[d]   = k[127-8*i -: 8];
            state_byte[d] = p[127-8*i -: 8];
            in_valid[d]   = 1'b1;
            ok = 1'b0;
            n = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = in_ready[d];
                if (ok) begin
                    t = cyc;
                    chk("load_pulse", 128'(load[d]), 128'(i == 15));
                end
                @(posedge clk); #1;
                n++;
            end
            if (!ok) chk("send_timeout", 128'(ok), 128'd1);
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic watch_rounds(input int d, input int lat);
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                chk("rnd_num", 128'(rnd_num_o[d]), 128'(r));
                chk("rnd_final", 128'(rnd_final_o[d]), 128'(r == 10));
                chk("busy_round", 128'(busy[d]), 128'd1);
                if (r == 10 && c == lat - 1) begin
                    chk("ready_pulse", 128'(ready[d]), 128'd1);
                    chk("no_early_valid", 128'(out_valid[d]), 128'd0);
                end
            end
        end
        @(negedge clk);
        chk("first_valid", 128'(out_valid[d]), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input int d, input int exp_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 128'(cyc), 128'(exp_cyc));
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 128'(exp_q.size()), 128'd0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("ready_after_drain", 128'(in_ready[d]), 128'd1);
        chk("valid_after_drain", 128'(out_valid[d]), 128'd0);
        chk("busy_after_drain", 128'(busy[d]), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rnd(input int d, input logic [3:0] r);
        int n;
        n = 0;
        @(negedge clk);
        while (rnd_num_o[d] != r && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round", 128'(rnd_num_o[d]), 128'(r));
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                case (ormode[d])
                    0:       out_ready[d] = 1'b1;
                    1:       out_ready[d] = ~out_ready[d];
                    default: out_ready[d] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    // Monitor: every accepted output byte is popped and compared.
    initial begin
        exp_t       e;
        logic [7:0] held[2];
        logic       stalled[2];
        stalled[0] = 1'b0;
        stalled[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (in_ready[d] && out_valid[d]) begin
                    checks++;
                    failures++;
                    $display("FAIL overlap inst=%0d in_ready and out_valid both 1", d);
                end
                if (stalled[d] && out_valid[d]) begin
                    checks++;
                    if (state_out_byte[d] !== held[d]) begin
                        failures++;
                        $display("FAIL stall_stable inst=%0d act=%h exp=%h",
                                 d, state_out_byte[d], held[d]);
                    end
                end
                if (out_valid[d] && out_ready[d]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_out inst=%0d byte=%h",
                                 d, state_out_byte[d]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.d != d || e.b !== state_out_byte[d]) begin
                            failures++;
                            $display("FAIL ct_byte inst=%0d act=%h exp=%h (inst %0d)",
                                     d, state_out_byte[d], e.b, e.d);
                        end
                    end
                end
                stalled[d] = out_valid[d] && !out_ready[d];
                held[d]    = state_out_byte[d];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           t;
        logic [127:0] k;
        logic [127:0] p;
        rst    = 1'b0;
        enable = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]   = 1'b1;
            key_byte[d]   = 8'h00;
            state_byte[d] = 8'h00;
            out_ready[d]  = 1'b1;
            ormode[d]     = 0;
        end

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 128'(in_ready[d]), 128'd0);
            chk("rst_out_valid", 128'(out_valid[d]), 128'd0);
            chk("rst_busy", 128'(busy[d]), 128'd0);
            chk("rst_rnd_num", 128'(rnd_num_o[d]), 128'd0);
            chk("rst_rnd_final", 128'(rnd_final_o[d]), 128'd0);
            chk("rst_rnd_state", rnd_state_o[d], 128'd0);
            chk("rst_rnd_key", rnd_key_o[d], 128'd0);
            chk("rst_load", 128'(load[d]), 128'd0);
            chk("rst_ready", 128'(ready[d]), 128'd0);
            chk("rst_out_byte", 128'(state_out_byte[d]), 128'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        chk("release_in_ready0", 128'(in_ready[0]), 128'd1);
        chk("release_in_ready1", 128'(in_ready[1]), 128'd1);
        @(posedge clk); #1;

        // FIPS-197 C.1, single-cycle round unit
        send_block(0, K1, P1, 1'b0, t);
        push_ct(0, C1);
        watch_rounds(0, 1);
        wait_drain(0);

        // all-zero vector with a toggling sink
        ormode[0] = 1;
        send_block(0, 128'd0, 128'd0, 1'b0, t);
        push_ct(0, CZ);
        wait_drain(0);
        ormode[0] = 0;

        // enable held low for five cycles in round 4
        send_block(0, K1, P1, 1'b0, t);
        push_ct(0, C1);
        wait_rnd(0, 4'd4);
        enable = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_rnd", 128'(rnd_num_o[0]), 128'd4);
            chk("hold_in_ready", 128'(in_ready[1]), 128'd0);
            chk("hold_out_valid", 128'(out_valid[0]), 128'd0);
        end
        enable = 1'b1;
        wait_out(0, t + 16);
        wait_drain(0);

        // reset in round 6 discards the block, next block is clean
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        send_block(0, k, p, 1'b0, t);
        wait_rnd(0, 4'd6);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_busy", 128'(busy[0]), 128'd0);
        chk("abort_rnd_num", 128'(rnd_num_o[0]), 128'd0);
        chk("abort_in_ready", 128'(in_ready[0]), 128'd0);
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_release", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        ormode[0] = 2;
        send_block(0, k, p, 1'b1, t);
        push_ct(0, aes_ref(k, p));
        wait_drain(0);
        ormode[0] = 0;

        // three-cycle round unit, C.1
        send_block(1, K1, P1, 1'b0, t);
        push_ct(1, C1);
        watch_rounds(1, 3);
        wait_drain(1);

        // random vectors on both latencies with random back-pressure
        for (int it = 0; it < 3; it++) begin
            for (int d = 0; d < 2; d++) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                p = {$urandom, $urandom, $urandom, $urandom};
                ormode[d] = 2;
                send_block(d, k, p, 1'b1, t);
                push_ct(d, aes_ref(k, p));
                wait_out(d, t + 1 + 10 * ((d == 0) ? 1 : 3));
                wait_drain(d);
                ormode[d] = 0;
            end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
